mips_ifu: RTL and testbench
===========================

Name: mips_ifu

Overview:
- Instruction-fetch stage of the single-cycle/pipelined MIPS core; sits directly upstream of the decode/datapath logic instantiated inside the mips top.
- Holds the PC and an internal word-addressed instruction ROM, and computes the next PC for sequential, branch, j/jal and jr flow.
- Registers {instr, pc, pc+4, valid} into an IF/ID output register, with stall and redirect (flush) control.

Parameters:
- IM_DEPTH, 1024, instruction ROM depth in 32-bit words; power of two.
- RESET_PC, 32'h0000_3000, PC value after reset and ROM base address.
- IM_INIT_FILE, "code.txt", hex file loaded into the ROM at elaboration.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID register (decode hazard).
- redir_sel  in  2  00 seq, 01 branch taken, 10 j/jal, 11 jr.
- redir_pc4  in  32  pc+4 of the redirecting instruction (from ID).
- imm16  in  16  branch offset field.
- idx26  in  26  jump instr_index field.
- jr_target  in  32  rs value for jr.
- if_instr  out  32  fetched instruction (registered).
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc + 4.
- if_valid  out  1  if_instr is a real fetch, not an inserted bubble.
- fault  out  1  fetch fault flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): pc_reg=RESET_PC; if_instr=32'h0000_0000 (nop); if_pc=0; if_pc4=0; if_valid=0; fault=0. Takes effect immediately, mid-cycle included; first fetch is on the first rising edge after rst returns high.
- ROM read is combinational from pc_reg. Index = (pc_reg - RESET_PC) >> 2, truncated to log2(IM_DEPTH) bits.
- Next-PC targets:
  - seq = pc_reg + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - branch = redir_pc4 + (sign_ext(imm16) << 2).
  - jump = {redir_pc4[31:28], idx26, 2'b00}.
  - jr = jr_target, used unmodified.
- Per-edge priority, highest first:
  1. redir_sel != 00: pc_reg <= target; IF/ID <= nop with if_valid=0. Redirect overrides a simultaneous stall. No delay slot: the wrong-path fetch is squashed, giving a 1-cycle redirect penalty.
  2. stall=1: pc_reg and IF/ID hold all values.
  3. otherwise: IF/ID <= {rom[index], pc_reg, pc_reg+4, valid=1}; pc_reg <= seq.
- Latency: the instruction at address A appears on if_instr one edge after pc_reg==A with no stall and no redirect.
- Redirect arriving while if_valid=0 is legal and behaves identically.
- Back-to-back redirects: each one is honoured; consecutive bubbles are emitted.

Optional Feature:
- Macro: IFU_FAULT_EN.
- Defined:
  - Fault condition: pc_reg[1:0] != 0, or pc_reg outside [RESET_PC, RESET_PC + 4*IM_DEPTH).
  - On the next edge after the condition: fault <= 1 (sticky until reset); IF/ID <= nop with valid=0; pc_reg frozen. Redirect and stall are then ignored.
- Undefined:
  - fault tied 0.
  - pc_reg[1:0] are ignored for indexing.
  - Out-of-range addresses alias modulo IM_DEPTH.

Decomposition:
- Shared package mips_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR 2-bit encodings.
  - NOP_INSTR = 32'h0.
  - DEFAULT_RESET_PC = 32'h0000_3000.
- One natural sub-module: mips_npc, purely combinational target/next-PC select. It is reusable by a later branch-in-EX variant.
- ROM and PC/IF-ID registers stay in mips_ifu.

Test Plan:
- Reset then release; ROM[0]=32'h3401_0005, ROM[1]=32'h3402_0007 -> after 1st edge if_pc=32'h3000, if_instr=32'h3401_0005, valid=1; after 2nd edge if_pc=32'h3004.
- Hold stall=1 for 3 cycles at if_pc=32'h3004 -> outputs and pc_reg unchanged; after release, next if_pc=32'h3008.
- Branch redir_sel=01, redir_pc4=32'h3008, imm16=16'hFFFE -> next edge bubble (valid=0); following edge if_pc=32'h3000.
- Jump redir_sel=10 with stall=1, redir_pc4=32'h3010, idx26=26'h0C05 -> redirect wins; bubble, then if_pc=32'h3014. jr with jr_target=32'h3020 -> if_pc=32'h3020.
- Drop rst low mid-cycle while stall=1 -> outputs clear immediately with no edge; pc_reg returns to 32'h3000.
- IFU_FAULT_EN defined, jr_target=32'h3002 -> bubble, then fault=1 sticky, pc frozen at 32'h3002. Without the macro: fetch ROM[0], fault=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared next-PC select encodings and fetch constants for the MIPS core.
// Rev 1.0 - initial release.
`default_nettype none

package mips_pkg;

    localparam logic [1:0]  NPC_SEQ          = 2'b00;
    localparam logic [1:0]  NPC_BR           = 2'b01;
    localparam logic [1:0]  NPC_J            = 2'b10;
    localparam logic [1:0]  NPC_JR           = 2'b11;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Word branch offset: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ifu_if.sv
// mips_ifu_if: redirect/stall controls into the fetch stage and the IF/ID register outputs.
// Rev 1.0 - initial release.
`default_nettype none

interface mips_ifu_if;

    logic        stall;
    logic [1:0]  redir_sel;
    logic [31:0] redir_pc4;
    logic [15:0] imm16;
    logic [25:0] idx26;
    logic [31:0] jr_target;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        fault;

    modport master (
        output stall, redir_sel, redir_pc4, imm16, idx26, jr_target,
        input  if_instr, if_pc, if_pc4, if_valid, fault
    );

    modport slave (
        input  stall, redir_sel, redir_pc4, imm16, idx26, jr_target,
        output if_instr, if_pc, if_pc4, if_valid, fault
    );

endinterface

`default_nettype wire

// File: rtl/mips_npc.sv
// mips_npc: combinational sequential/branch/jump/jr target computation and next-PC select.
// Rev 1.0 - initial release.
`default_nettype none

module mips_npc
    import mips_pkg::*;
(
    input  wire logic [31:0] pc_i,
    input  wire logic [1:0]  sel_i,
    input  wire logic [31:0] redir_pc4_i,
    input  wire logic [15:0] imm16_i,
    input  wire logic [25:0] idx26_i,
    input  wire logic [31:0] jr_target_i,
    output logic      [31:0] seq_pc_o,
    output logic      [31:0] next_pc_o
);

    always_comb begin
        seq_pc_o  = pc_i + 32'd4;
        next_pc_o = seq_pc_o;
        unique case (sel_i)
            NPC_BR:  next_pc_o = redir_pc4_i + br_offset(imm16_i);
            NPC_J:   next_pc_o = {redir_pc4_i[31:28], idx26_i, 2'b00};
            NPC_JR:  next_pc_o = jr_target_i;
            default: next_pc_o = seq_pc_o;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_ifu.sv
// mips_ifu: PC, instruction ROM and IF/ID register with stall and redirect/flush.
// Optional macro IFU_FAULT_EN: sticky fetch fault on misaligned or out-of-ROM PC. Rev 1.0.
`default_nettype none

module mips_ifu
    import mips_pkg::*;
#(
    parameter int          IM_DEPTH     = 1024,
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter string       IM_INIT_FILE = "code.txt"
)
(
    input  wire logic  clk,
    input  wire logic  rst,
    mips_ifu_if.slave  bus
);

    localparam int AW = $clog2(IM_DEPTH);

    // ROM contents are preloaded from IM_INIT_FILE by the memory-init flow.
    logic [31:0] rom [IM_DEPTH];

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q,  ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_seq_pc;
    logic [31:0]   w_next_pc;
    logic          unused_off_bits;

    assign w_off           = pc_q - RESET_PC;
    assign w_idx           = w_off[AW+1:2];
    assign unused_off_bits = ^{w_off[31:AW+2], w_off[1:0]};

    mips_npc u_npc (
        .pc_i        (pc_q),
        .sel_i       (bus.redir_sel),
        .redir_pc4_i (bus.redir_pc4),
        .imm16_i     (bus.imm16),
        .idx26_i     (bus.idx26),
        .jr_target_i (bus.jr_target),
        .seq_pc_o    (w_seq_pc),
        .next_pc_o   (w_next_pc)
    );

`ifdef IFU_FAULT_EN
    logic fault_q, fault_d;
    logic w_fault_cond;

    assign w_fault_cond = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) ||
                          ({1'b0, w_off} >= 33'(4 * IM_DEPTH));
    assign bus.fault    = fault_q;
`else
    assign bus.fault    = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
`ifdef IFU_FAULT_EN
        fault_d = fault_q;
        if (fault_q) begin
            pc_d = pc_q;
        end else if (w_fault_cond) begin
            fault_d = 1'b1;
            instr_d = NOP_INSTR;
            ifpc_d  = 32'h0;
            ifpc4_d = 32'h0;
            valid_d = 1'b0;
        end else
`endif
        if (bus.redir_sel != NPC_SEQ) begin
            // Redirect beats stall; the wrong-path fetch becomes a bubble.
            pc_d    = w_next_pc;
            instr_d = NOP_INSTR;
            ifpc_d  = 32'h0;
            ifpc4_d = 32'h0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d    = w_next_pc;
            instr_d = rom[w_idx];
            ifpc_d  = pc_q;
            ifpc4_d = w_seq_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'h0;
            ifpc4_q <= 32'h0;
            valid_q <= 1'b0;
`ifdef IFU_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
`ifdef IFU_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.if_instr = instr_q;
    assign bus.if_pc    = ifpc_q;
    assign bus.if_pc4   = ifpc4_q;
    assign bus.if_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_ifu.sv
// tb_mips_ifu: directed vector table plus hand sequences for reset, mid-cycle reset and fetch fault.
// Rev 1.0 - initial release.
`default_nettype none

module tb_mips_ifu;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_ifu_if bus();

    mips_ifu #(
        .IM_DEPTH     (1024),
        .RESET_PC     (32'h0000_3000),
        .IM_INIT_FILE ("code.txt")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] pc4;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] model_rom [128];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] sel, input logic [31:0] pc4,
                         input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
        bus.stall     = s;
        bus.redir_sel = sel;
        bus.redir_pc4 = pc4;
        bus.imm16     = imm;
        bus.idx26     = idx;
        bus.jr_target = jr;
    endtask

    task automatic add_vec(input logic s, input logic [1:0] sel, input logic [31:0] pc4,
                           input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr,
                           input logic ev, input logic [31:0] epc);
        vec_t v;
        v.stall = s; v.sel = sel; v.pc4 = pc4; v.imm = imm;
        v.idx = idx; v.jr = jr; v.ev = ev; v.epc = epc;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - 32'h0000_3000) >> 2;
        return model_rom[off[6:0]];
    endfunction

    task automatic chk_fetch(input string nm, input logic [31:0] epc);
        chk({nm, ".valid"}, {31'b0, bus.if_valid}, 32'd1);
        chk({nm, ".pc"},    bus.if_pc,    epc);
        chk({nm, ".pc4"},   bus.if_pc4,   epc + 32'd4);
        chk({nm, ".instr"}, bus.if_instr, exp_instr(epc));
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, ".valid"}, {31'b0, bus.if_valid}, 32'd0);
        chk({nm, ".instr"}, bus.if_instr, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        for (int i = 0; i < 128; i++) model_rom[i] = 32'h2400_0000 | i;
        model_rom[0] = 32'h3401_0005;
        model_rom[1] = 32'h3402_0007;
        for (int i = 0; i < 128; i++) dut.rom[i] = model_rom[i];

        #1;
        chk("rst.instr", bus.if_instr, 32'h0);
        chk("rst.pc",    bus.if_pc,    32'h0);
        chk("rst.pc4",   bus.if_pc4,   32'h0);
        chk("rst.valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst.fault", {31'b0, bus.fault},    32'd0);

        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3000);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3004);
        add_vec(1, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3004);
        add_vec(1, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3004);
        add_vec(1, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3004);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3008);
        add_vec(0, NPC_BR,  32'h3008, 16'hFFFE, 26'h0,    32'h0,    0, 32'h0);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3000);
        add_vec(1, NPC_J,   32'h3010, 16'h0,    26'h0C05, 32'h0,    0, 32'h0);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3014);
        add_vec(0, NPC_JR,  32'h0,    16'h0,    26'h0,    32'h3020, 0, 32'h0);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3020);
        add_vec(0, NPC_JR,  32'h0,    16'h0,    26'h0,    32'h3004, 0, 32'h0);
        add_vec(0, NPC_BR,  32'h3100, 16'h0003, 26'h0,    32'h0,    0, 32'h0);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h310C);
        add_vec(0, NPC_JR,  32'h0,    16'h0,    26'h0,    32'h3000, 0, 32'h0);
        add_vec(1, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    0, 32'h0);
        add_vec(0, NPC_SEQ, 32'h0,    16'h0,    26'h0,    32'h0,    1, 32'h3000);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].stall, vq[i].sel, vq[i].pc4, vq[i].imm, vq[i].idx, vq[i].jr);
            @(posedge clk);
            #1;
            if (vq[i].ev) chk_fetch($sformatf("vec%0d", i), vq[i].epc);
            else          chk_bubble($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.fault", i), {31'b0, bus.fault}, 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset asserted mid-cycle while stalled.
        drive(1'b1, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.instr", bus.if_instr, 32'h0);
        chk("midrst.pc",    bus.if_pc,    32'h0);
        chk("midrst.valid", {31'b0, bus.if_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_fetch("postrst", 32'h3000);

        // Misaligned jr target.
        @(negedge clk);
        drive(1'b0, NPC_JR, 32'h0, 16'h0, 26'h0, 32'h3002);
        @(posedge clk);
        #1;
        chk_bubble("mis.redir");
        @(negedge clk);
        drive(1'b0, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
`ifdef IFU_FAULT_EN
        chk("mis.fault", {31'b0, bus.fault}, 32'd1);
        chk_bubble("mis.fetch");
`else
        chk("mis.fault", {31'b0, bus.fault}, 32'd0);
        chk_fetch("mis.fetch", 32'h3002);
`endif
        @(negedge clk);
        drive(1'b0, NPC_JR, 32'h0, 16'h0, 26'h0, 32'h3000);
        @(posedge clk);
        #1;
        chk_bubble("mis.after");
`ifdef IFU_FAULT_EN
        chk("mis.sticky", {31'b0, bus.fault}, 32'd1);
        @(negedge clk);
        drive(1'b0, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("mis.sticky2", {31'b0, bus.fault}, 32'd1);
        chk_bubble("mis.frozen");
`else
        chk("mis.nofault", {31'b0, bus.fault}, 32'd0);
        @(negedge clk);
        drive(1'b0, NPC_SEQ, 32'h0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_fetch("mis.resume", 32'h3000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
